// File: rtl/multi_port_fifo.sv
// multi_port_fifo: multi-lane synchronous FIFO with flush, occupancy counts and overflow flag
module multi_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [WR_PORTS-1:0]              wr_en,
  input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  input  logic [RD_PORTS-1:0]              rd_en,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_PORTS-1:0]              rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [$clog2(DEPTH+1)-1:0]       free_cnt,
  output logic                             empty,
  output logic                             full,
  output logic                             wr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d, n_wr, n_rd;
  logic [AW-1:0] off [WR_PORTS];
  logic acc, run, ovf_q;
  assign count       = count_q;
  assign free_cnt    = CW'(DEPTH) - count_q;
  assign empty       = count_q == '0;
  assign full        = free_cnt < CW'(WR_PORTS);
  assign wr_overflow = ovf_q;
  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    assign rd_valid[g] = count_q > CW'(g);
    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[head_q + AW'(g)];
  end
  // Compact write lanes, decide whole-group acceptance, and measure the leading pop run
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      off[i] = n_wr[AW-1:0];
      n_wr   = n_wr + CW'(wr_en[i]);
    end
    acc  = n_wr <= free_cnt;
    run  = 1'b1;
    n_rd = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      run  = run & rd_en[i] & rd_valid[i];
      n_rd = n_rd + CW'(run);
    end
    count_d = count_q + (acc ? n_wr : '0) - n_rd;
  end
  // Pointers, occupancy and overflow pulse; flush clears like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_q + n_rd[AW-1:0];
      tail_q  <= tail_q + (acc ? n_wr[AW-1:0] : '0);
      count_q <= count_d;
      ovf_q   <= !acc;
    end
  end
  // Storage is never cleared; accepted lanes land at consecutive slots from tail
  always_ff @(posedge clk) begin
    if (!rst && !flush && acc)
      for (int i = 0; i < WR_PORTS; i++)
        if (wr_en[i]) mem_q[tail_q + off[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule
